// File: rtl/wb_sram_bridge.sv
// Pipelined Wishbone slave bridging the J1 CPU bus to an asynchronous 16-bit SRAM.
// All SRAM strobes come straight from flops; wait states are set by RD_WAIT/WR_WAIT.
module wb_sram_bridge #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [15:0]       wb_adr,
  input  logic [15:0]       wb_dat_i,
  output logic [15:0]       wb_dat_o,
  output logic              wb_ack,
  output logic              wb_stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic [15:0]       dat_q, dat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dq_o_q, dq_o_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [ADDR_W-1:0] adr_ext;
  logic              accept;

  generate
    if (ADDR_W <= 16) begin : g_trunc
      logic [15:0] unused_adr_bits;
      assign unused_adr_bits = wb_adr;
      assign adr_ext         = wb_adr[ADDR_W-1:0];
    end else begin : g_zext
      assign adr_ext = {{(ADDR_W-16){1'b0}}, wb_adr};
    end
  endgenerate

  assign wb_stall = (state_q != IDLE) || !reset;
  assign accept   = wb_cyc && wb_stb && !wb_stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    addr_d  = addr_q;
    dq_o_d  = dq_o_q;
    dq_oe_d = dq_oe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = adr_ext;
          dq_o_d = wb_dat_i;
          ce_n_d = 1'b0;
          if (wb_we) begin
            state_d = WRITE;
            cnt_d   = 5'(WR_WAIT + 1);
            oe_n_d  = 1'b1;
            we_n_d  = 1'b0;
            dq_oe_d = 1'b1;
          end else begin
            state_d = READ;
            cnt_d   = 5'(RD_WAIT);
            oe_n_d  = 1'b0;
            we_n_d  = 1'b1;
            dq_oe_d = 1'b0;
          end
        end
      end
      READ: begin
        if (cnt_q == 5'd0) begin
          state_d = IDLE;
          dat_d   = sram_dq_i;
          ack_d   = wb_cyc;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      WRITE: begin
        if (cnt_q == 5'd0) begin
          state_d = IDLE;
          ack_d   = wb_cyc;
          ce_n_d  = 1'b1;
          we_n_d  = 1'b1;
          dq_oe_d = 1'b0;
        end else begin
          cnt_d  = cnt_q - 5'd1;
          // we_n is a flop, so release it one cycle early to leave an address/data hold cycle
          we_n_d = (cnt_q == 5'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign wb_ack     = ack_q;
  assign wb_dat_o   = dat_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_ub_n  = ce_n_q;
  assign sram_lb_n  = ce_n_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Bench for wb_sram_bridge: two instances (RD/WR waits 1/1 and 0/3, ADDR_W 16 and 8)
// driven by randomized Wishbone traffic and checked against a transaction-level model.
module tb_wb_sram_bridge;

  localparam int unsigned RDW0 = 1;
  localparam int unsigned WRW0 = 1;
  localparam int unsigned RDW1 = 0;
  localparam int unsigned WRW1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n, cyc, stb, we;
  logic [1:0][15:0] adr, dat_i;
  logic [1:0][15:0] dat_o, dq_o;
  logic [1:0]       ack, stall, dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;
  logic [15:0]      addr0;
  logic [7:0]       addr1;
  logic [15:0]      dq_i0, dq_i1;

  wb_sram_bridge #(.ADDR_W(16), .RD_WAIT(RDW0), .WR_WAIT(WRW0)) dut0 (
    .clk(clk), .reset(rst_n[0]), .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we[0]),
    .wb_adr(adr[0]), .wb_dat_i(dat_i[0]), .wb_dat_o(dat_o[0]), .wb_ack(ack[0]),
    .wb_stall(stall[0]), .sram_addr(addr0), .sram_dq_o(dq_o[0]), .sram_dq_i(dq_i0),
    .sram_dq_oe(dq_oe[0]), .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]),
    .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0])
  );

  wb_sram_bridge #(.ADDR_W(8), .RD_WAIT(RDW1), .WR_WAIT(WRW1)) dut1 (
    .clk(clk), .reset(rst_n[1]), .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we[1]),
    .wb_adr(adr[1]), .wb_dat_i(dat_i[1]), .wb_dat_o(dat_o[1]), .wb_ack(ack[1]),
    .wb_stall(stall[1]), .sram_addr(addr1), .sram_dq_o(dq_o[1]), .sram_dq_i(dq_i1),
    .sram_dq_oe(dq_oe[1]), .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]),
    .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1])
  );

  // Asynchronous SRAM models: 256 words each, indexed by the low address byte.
  logic [15:0] sram_mem [2][256];
  bit          seeded = 1'b0;

  function automatic logic [15:0] init_word(input int k, input int i);
    if (i == 'h42) return 16'hBEEF;
    return 16'((i * 40503 + k * 7919 + 13) ^ (i << 7));
  endfunction

  always @(negedge clk) begin
    if (!seeded) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 256; i++) sram_mem[k][i] = init_word(k, i);
      seeded = 1'b1;
    end
    if (!ce_n[0] && !we_n[0] && dq_oe[0]) sram_mem[0][addr0[7:0]] = dq_o[0];
    if (!ce_n[1] && !we_n[1] && dq_oe[1]) sram_mem[1][addr1] = dq_o[1];
  end

  assign dq_i0 = (!ce_n[0] && !oe_n[0]) ? sram_mem[0][addr0[7:0]] : 16'h0BAD;
  assign dq_i1 = (!ce_n[1] && !oe_n[1]) ? sram_mem[1][addr1] : 16'h0BAD;

  // Reference model: contents as seen by completed transactions, last read data.
  logic [15:0] ref_mem [2][256];
  logic [15:0] last_rd [2];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rd_wait(input int k);
    return (k == 0) ? int'(RDW0) : int'(RDW1);
  endfunction

  function automatic int wr_wait(input int k);
    return (k == 0) ? int'(WRW0) : int'(WRW1);
  endfunction

  // {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, stall, ack}
  function automatic logic [7:0] pins(input int k);
    return {ce_n[k], oe_n[k], we_n[k], ub_n[k], lb_n[k], dq_oe[k], stall[k], ack[k]};
  endfunction

  function automatic logic [15:0] sram_addr_of(input int k);
    return (k == 0) ? addr0 : {8'h00, addr1};
  endfunction

  task automatic junk(input int k, input bit keep_cyc, input bit hold);
    cyc[k]   = keep_cyc;
    stb[k]   = hold ? 1'b1 : 1'($urandom);
    we[k]    = 1'($urandom);
    adr[k]   = 16'($urandom);
    dat_i[k] = 16'($urandom);
  endtask

  // Called at a negedge with instance k idle; returns at the negedge of the ack cycle.
  task automatic txn(input int k, input bit w, input logic [15:0] a, input logic [15:0] d,
                     input bit abort, input bit hold);
    int          n;
    logic [15:0] ea;
    logic [7:0]  exp_p;
    n  = w ? wr_wait(k) + 2 : rd_wait(k) + 1;
    ea = (k == 0) ? a : {8'h00, a[7:0]};
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dat_i[k] = d;
    #1;
    check($sformatf("i%0d accept_stall", k), 32'(stall[k]), 0);
    if (w) ref_mem[k][a[7:0]] = d;
    else   last_rd[k] = ref_mem[k][a[7:0]];
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      junk(k, !abort, hold);
      @(negedge clk);
      exp_p = {1'b0, w, (w ? (c == n) : 1'b1), 1'b0, 1'b0, w, 1'b1, 1'b0};
      check($sformatf("i%0d %s c%0d pins", k, w ? "wr" : "rd", c), 32'(pins(k)), 32'(exp_p));
      check($sformatf("i%0d c%0d sram_addr", k, c), 32'(sram_addr_of(k)), 32'(ea));
      if (w) check($sformatf("i%0d c%0d sram_dq_o", k, c), 32'(dq_o[k]), 32'(d));
    end
    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("i%0d ack_cycle pins", k), 32'(pins(k)), 32'({7'b1111100, !abort}));
    check($sformatf("i%0d wb_dat_o", k), 32'(dat_o[k]), 32'(last_rd[k]));
    cyc[k] = 1'b0; stb[k] = 1'b0;
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0:       begin cyc[k] = 1'b0; stb[k] = 1'b0; end
        1:       begin cyc[k] = 1'b0; stb[k] = 1'b1; end
        default: begin cyc[k] = 1'b1; stb[k] = 1'b0; end
      endcase
      we[k] = 1'($urandom); adr[k] = 16'($urandom); dat_i[k] = 16'($urandom);
      @(negedge clk);
      check($sformatf("i%0d idle pins", k), 32'(pins(k)), 32'(8'b11111000));
      check($sformatf("i%0d idle wb_dat_o", k), 32'(dat_o[k]), 32'(last_rd[k]));
    end
    cyc[k] = 1'b0; stb[k] = 1'b0;
  endtask

  task automatic reset_mid_write(input int k, input logic [15:0] a, input logic [15:0] d);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1; adr[k] = a; dat_i[k] = d;
    ref_mem[k][a[7:0]] = d;
    @(posedge clk); #1;
    junk(k, 1'b1, 1'b0);
    @(negedge clk);
    check($sformatf("i%0d rstw c1 pins", k), 32'(pins(k)), 32'(8'b01000110));
    @(posedge clk); #1;
    rst_n[k] = 1'b0;
    @(negedge clk);
    check($sformatf("i%0d rstw c2 pins", k), 32'(pins(k)), 32'(8'b01000110));
    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("i%0d rstw c3 pins", k), 32'(pins(k)), 32'(8'b11111010));
    check($sformatf("i%0d rstw wb_dat_o", k), 32'(dat_o[k]), 0);
    check($sformatf("i%0d rstw sram_addr", k), 32'(sram_addr_of(k)), 0);
    check($sformatf("i%0d rstw sram_dq_o", k), 32'(dq_o[k]), 0);
    last_rd[k] = 16'h0000;
    rst_n[k] = 1'b1;
    cyc[k] = 1'b0; stb[k] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int          k;
    bit          w;
    logic [15:0] a;
    rst_n = 2'b00; cyc = 2'b11; stb = 2'b11; we = 2'b00;
    adr = '0; dat_i = '0;
    for (int j = 0; j < 2; j++) begin
      last_rd[j] = 16'h0000;
      for (int i = 0; i < 256; i++) ref_mem[j][i] = init_word(j, i);
    end

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        check($sformatf("i%0d reset pins", j), 32'(pins(j)), 32'(8'b11111010));
        check($sformatf("i%0d reset wb_dat_o", j), 32'(dat_o[j]), 0);
        check($sformatf("i%0d reset sram_addr", j), 32'(sram_addr_of(j)), 0);
      end
    end
    rst_n = 2'b11; cyc = 2'b00; stb = 2'b00;

    txn(0, 1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0);
    check("i0 beef_read", 32'(dat_o[0]), 32'h0000BEEF);
    txn(0, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0);
    txn(0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
    check("i0 readback_1234", 32'(dat_o[0]), 32'h00001234);

    for (int i = 0; i < 4; i++) txn(1, 1'b0, 16'(i), 16'h0000, 1'b0, i < 3);

    txn(0, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b0);
    idle(0, 2);
    txn(0, 1'b1, 16'h0020, 16'h5555, 1'b1, 1'b0);
    txn(0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);
    txn(0, 1'b0, 16'h8042, 16'h0000, 1'b0, 1'b0);
    txn(1, 1'b1, 16'hAB07, 16'hCAFE, 1'b0, 1'b0);
    txn(1, 1'b0, 16'h0007, 16'h0000, 1'b0, 1'b0);

    reset_mid_write(1, 16'h0009, 16'h7777);
    idle(1, 3);
    txn(1, 1'b0, 16'h0009, 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 1);
      w = 1'($urandom);
      a = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
      txn(k, w, a, 16'($urandom), $urandom_range(0, 9) == 0, 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle(k, $urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_sram_bridge.md
Name: wb_sram_bridge

Overview:
- Pipelined Wishbone slave that connects the J1 CPU bus to an external asynchronous 16-bit SRAM.
- Sits directly downstream of the CPU's Wishbone master. It serves both instruction fetches and data loads/stores, using the single shared port the CPU drives.
- Inserts configurable read and write wait states and holds the master off with wb_stall while an access is in flight.
- All SRAM strobes are driven from flops so they are glitch-free.

Parameters:
ADDR_W, 16, SRAM word-address width (legal 1..20); wb_adr is zero-extended or truncated to ADDR_W.
RD_WAIT, 1, extra read-access cycles (legal 0..15).
WR_WAIT, 1, extra write-pulse cycles (legal 0..15).

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset (0 = reset).
wb_cyc  in  1  Wishbone cycle.
wb_stb  in  1  Wishbone strobe.
wb_we  in  1  1 = write, 0 = read.
wb_adr  in  16  word address.
wb_dat_i  in  16  write data from master.
wb_dat_o  out  16  read data to master; valid when wb_ack=1.
wb_ack  out  1  one-cycle completion pulse.
wb_stall  out  1  slave busy; request not accepted.
sram_addr  out  ADDR_W  SRAM address.
sram_dq_o  out  16  SRAM write data.
sram_dq_i  in  16  SRAM read data.
sram_dq_oe  out  1  1 = drive data bus (top level builds the tristate).
sram_ce_n  out  1  chip enable, active low.
sram_oe_n  out  1  output enable, active low.
sram_we_n  out  1  write enable, active low.
sram_ub_n  out  1  upper byte enable; equals sram_ce_n (full-word access only).
sram_lb_n  out  1  lower byte enable; equals sram_ce_n.

Behaviour:
- Reset values (reset=0 at a clock edge; takes effect at that edge, including mid-access):
  - state=IDLE, wb_ack=0, wb_dat_o=0.
  - sram_ce_n/oe_n/we_n/ub_n/lb_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
  - An in-flight write is abandoned; no ack follows.
- wb_stall = (state!=IDLE) || !reset.
  - Combinational from state and reset only; there is no path from wb_stb/wb_cyc to wb_stall.
- Acceptance:
  - A request is accepted at an edge where wb_cyc && wb_stb && !wb_stall.
  - At acceptance, wb_adr, wb_we and wb_dat_i are latched.
  - State goes to READ with cnt=RD_WAIT, or to WRITE with cnt=WR_WAIT+1.
- FSM states: IDLE, READ, WRITE.
- READ (lasts RD_WAIT+1 cycles):
  - ce_n=0, oe_n=0, we_n=1, dq_oe=0, sram_addr=latched address.
  - cnt decrements each edge.
  - At the edge where cnt==0: wb_dat_o<=sram_dq_i, wb_ack<=wb_cyc, state<=IDLE.
- WRITE (lasts WR_WAIT+2 cycles):
  - ce_n=0, oe_n=1, dq_oe=1, sram_dq_o=latched data, sram_addr=latched address.
  - we_n=0 while cnt!=0; we_n=1 in the final cycle, which provides address/data hold.
  - At the edge where cnt==0: wb_ack<=wb_cyc, state<=IDLE. wb_dat_o is unchanged.
- Latency (acceptance at the edge ending cycle 0):
  - Read: ack high in cycle RD_WAIT+2.
  - Write: ack high in cycle WR_WAIT+3.
- wb_ack is high for exactly one cycle. It must never be asserted in a cycle where the preceding access had no acceptance.
- Back-to-back: the ack cycle is in IDLE, so a new request can be accepted in the same cycle as the ack. There are no idle bubbles beyond the wait states.
- Abort: if wb_cyc falls mid-access, the SRAM access still runs to completion (no truncated write pulse), but wb_ack is suppressed.
- wb_stb without wb_cyc is ignored.
- Address: sram_addr = wb_adr[ADDR_W-1:0] if ADDR_W<=16, else zero-extended.
- sram_ub_n and sram_lb_n track sram_ce_n every cycle.
- The cnt register is 5 bits wide. There is no wrap-around: cnt is reloaded on every acceptance.

Test Plan:
- Reset hold: reset=0 for 3 cycles with wb_cyc=wb_stb=1 -> wb_stall=1, wb_ack=0, all SRAM strobes 1, dq_oe=0 throughout.
- Single read, RD_WAIT=1: SRAM model word 0x0042=0xBEEF, read accepted in cycle 0 -> ce_n/oe_n low in cycles 1-2, wb_ack=1 with wb_dat_o=0xBEEF in cycle 3, wb_stall=1 in cycles 1-2.
- Write then readback, WR_WAIT=1: write 0x1234 to 0x0010 -> we_n low in cycles 1-2, high in cycle 3 with dq_oe=1, ack in cycle 4. A read of 0x0010 issued in the ack cycle returns 0x1234 with ack in cycle 7.
- RD_WAIT=0 back-to-back: 4 reads of 0x0000..0x0003 held with stb=1 -> one ack every 2 cycles with data matching the model, each address accepted exactly once.
- Abort: read accepted, wb_cyc dropped in cycle 1 -> SRAM access still runs to completion, no wb_ack, wb_stall=0 by cycle 3.
- Reset mid-write: assert reset=0 in cycle 2 of a WR_WAIT=3 write -> at that edge we_n=1, ce_n=1, dq_oe=0, no ack after reset is released, and the next request is accepted normally.
